sobel_edge: RTL and testbench

- Consumes the registered 3x3 grayscale window produced by the line buffer stage and computes a Sobel gradient magnitude plus a thresholded edge bit per pixel.
- Three-stage pipeline with valid tracking.
- Column/row counters mask windows that straddle a line or frame boundary.
- Output feeds the feature/overlay stage of the passport pipeline.

---
 rtl/sobel_edge.sv | 130 +++++++++++++
 tb/tb_sobel_edge.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge.sv
// Sobel gradient magnitude and thresholded edge bit over a registered 3x3 window.
// Three-stage pipeline; windows that straddle a line or frame boundary are masked to zero.
module sobel_edge #(
  parameter int LINE_LEN  = 640,
  parameter int NUM_LINES = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic [7:0] a0,
  input  logic [7:0] a1,
  input  logic [7:0] a2,
  input  logic [7:0] a7,
  input  logic [7:0] pix,
  input  logic [7:0] a3,
  input  logic [7:0] a6,
  input  logic [7:0] a5,
  input  logic [7:0] a4,
  input  logic [7:0] thresh,
  output logic       out_valid,
  output logic [7:0] edge_mag,
  output logic       edge_bit,
  output logic       out_sof
);

  localparam int CW = (LINE_LEN > 4) ? $clog2(LINE_LEN) : 2;
  localparam int RW = (NUM_LINES > 4) ? $clog2(NUM_LINES) : 2;
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_LEN - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(NUM_LINES - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_mask;

  logic [10:0]        w_gxPos, w_gxNeg, w_gyPos, w_gyNeg;
  logic signed [10:0] w_gx, w_gy;
  logic signed [10:0] r_gx, r_gy;
  logic               r_valid1, r_sof1, r_mask1;

  logic [10:0] w_absGx, w_absGy, w_mag;
  logic [10:0] r_mag;
  logic        r_valid2, r_sof2, r_mask2;

  logic [7:0] w_sat;
  logic       w_unused;

  // The centre pixel carries zero weight in both kernels.
  assign w_unused = ^pix;

  assign w_col  = (in_valid && in_sof) ? '0 : r_col;
  assign w_row  = (in_valid && in_sof) ? '0 : r_row;
  assign w_mask = (w_col < CW'(2)) || (w_row < RW'(2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (in_valid) begin
      if (w_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
      end else begin
        r_col <= w_col + CW'(1);
        r_row <= w_row;
      end
    end
  end

  assign w_gxPos = 11'(a2) + 11'({a3, 1'b0}) + 11'(a4);
  assign w_gxNeg = 11'(a0) + 11'({a7, 1'b0}) + 11'(a6);
  assign w_gyPos = 11'(a6) + 11'({a5, 1'b0}) + 11'(a4);
  assign w_gyNeg = 11'(a0) + 11'({a1, 1'b0}) + 11'(a2);
  assign w_gx    = w_gxPos - w_gxNeg;
  assign w_gy    = w_gyPos - w_gyNeg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gx     <= '0;
      r_gy     <= '0;
      r_valid1 <= 1'b0;
      r_sof1   <= 1'b0;
      r_mask1  <= 1'b0;
    end else begin
      r_gx     <= w_gx;
      r_gy     <= w_gy;
      r_valid1 <= in_valid;
      r_sof1   <= in_valid & in_sof;
      r_mask1  <= w_mask;
    end
  end

  assign w_absGx = r_gx[10] ? 11'(-r_gx) : r_gx;
  assign w_absGy = r_gy[10] ? 11'(-r_gy) : r_gy;
  assign w_mag   = w_absGx + w_absGy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mag    <= '0;
      r_valid2 <= 1'b0;
      r_sof2   <= 1'b0;
      r_mask2  <= 1'b0;
    end else begin
      r_mag    <= w_mag;
      r_valid2 <= r_valid1;
      r_sof2   <= r_sof1;
      r_mask2  <= r_mask1;
    end
  end

  assign w_sat = (r_mag > 11'd255) ? 8'hFF : r_mag[7:0];

  // Bubbles and masked windows both present an all-zero result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      edge_mag  <= '0;
      edge_bit  <= 1'b0;
      out_sof   <= 1'b0;
    end else begin
      out_valid <= r_valid2;
      edge_mag  <= (r_valid2 && !r_mask2) ? w_sat : 8'd0;
      edge_bit  <= r_valid2 && !r_mask2 && (w_sat >= thresh);
      out_sof   <= r_valid2 & r_sof2;
    end
  end

endmodule

// File: tb/tb_sobel_edge.sv
// Self-checking bench for sobel_edge: a reference model pushes expected results
// into a scoreboard at drive time; a negedge monitor pops and compares them.
module tb_sobel_edge;

  localparam int LL = 8;
  localparam int NL = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_sof;
  logic [7:0] a0, a1, a2, a7, pix, a3, a6, a5, a4;
  logic [7:0] thresh;
  logic       out_valid;
  logic [7:0] edge_mag;
  logic       edge_bit;
  logic       out_sof;

  typedef struct {
    int         due;
    logic [7:0] mag;
    logic       ebit;
    logic       sof;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   assertCount = 0;
  int   failCount = 0;
  int   mcol = 0;
  int   mrow = 0;
  bit   checkEn = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sobel_edge #(.LINE_LEN(LL), .NUM_LINES(NL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .a0(a0), .a1(a1), .a2(a2), .a7(a7), .pix(pix), .a3(a3),
    .a6(a6), .a5(a5), .a4(a4), .thresh(thresh),
    .out_valid(out_valid), .edge_mag(edge_mag), .edge_bit(edge_bit), .out_sof(out_sof)
  );

  // Arguments follow the window layout: top row, middle row, bottom row.
  task automatic applyStimulus(input bit v, input bit s,
                               input int p0, input int p1, input int p2,
                               input int p7, input int pc, input int p3,
                               input int p6, input int p5, input int p4);
    int   gx, gy, mag;
    bit   masked;
    exp_t e;
    if (v) begin
      if (s) begin
        mcol = 0;
        mrow = 0;
      end
      masked = (mcol < 2) || (mrow < 2);
      gx  = (p2 + 2 * p3 + p4) - (p0 + 2 * p7 + p6);
      gy  = (p6 + 2 * p5 + p4) - (p0 + 2 * p1 + p2);
      mag = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
      if (mag > 255) mag = 255;
      if (masked) mag = 0;
      e.due  = cyc + 3;
      e.mag  = 8'(mag);
      e.ebit = !masked && (mag >= int'(thresh));
      e.sof  = s;
      sb.push_back(e);
      if (mcol == LL - 1) begin
        mcol = 0;
        mrow = (mrow == NL - 1) ? 0 : mrow + 1;
      end else begin
        mcol = mcol + 1;
      end
    end
    in_valid = v;
    in_sof   = s;
    a0 = 8'(p0); a1 = 8'(p1); a2 = 8'(p2);
    a7 = 8'(p7); pix = 8'(pc); a3 = 8'(p3);
    a6 = 8'(p6); a5 = 8'(p5); a4 = 8'(p4);
    @(posedge clk);
    #1;
  endtask

  task automatic edgeWin(input bit v, input bit s);
    applyStimulus(v, s, 0, 0, 255, 0, 128, 255, 0, 0, 255);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ensureUnmasked();
    for (int i = 0; i < LL * NL && ((mcol < 2) || (mrow < 2)); i++) edgeWin(1, 0);
  endtask

  task automatic checkOutput();
    bit   expV;
    exp_t e;
    expV = (sb.size() > 0) && (sb[0].due == cyc);
    assertCount++;
    assert (out_valid === expV) else begin
      failCount++;
      $error("[TB] FAIL out_valid cyc=%0d observed=%b expected=%b", cyc, out_valid, expV);
    end
    if (expV) begin
      e = sb.pop_front();
      assertCount++;
      assert (edge_mag === e.mag) else begin
        failCount++;
        $error("[TB] FAIL edge_mag cyc=%0d observed=%0d expected=%0d", cyc, edge_mag, e.mag);
      end
      assertCount++;
      assert (edge_bit === e.ebit) else begin
        failCount++;
        $error("[TB] FAIL edge_bit cyc=%0d observed=%b expected=%b", cyc, edge_bit, e.ebit);
      end
      assertCount++;
      assert (out_sof === e.sof) else begin
        failCount++;
        $error("[TB] FAIL out_sof cyc=%0d observed=%b expected=%b", cyc, out_sof, e.sof);
      end
    end else begin
      assertCount++;
      assert ({edge_mag, edge_bit, out_sof} === 10'b0) else begin
        failCount++;
        $error("[TB] FAIL idle_outputs cyc=%0d observed=%h expected=0", cyc, {edge_mag, edge_bit, out_sof});
      end
    end
  endtask

  always @(negedge clk) if (checkEn) checkOutput();

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_sof = 1'b0;
    a0 = '0; a1 = '0; a2 = '0; a7 = '0; pix = '0; a3 = '0; a6 = '0; a5 = '0; a4 = '0;
    thresh = 8'd200;
    repeat (3) @(posedge clk);
    #1;
    assertCount++;
    assert ({out_valid, edge_mag, edge_bit, out_sof} === 11'b0) else begin
      failCount++;
      $error("[TB] FAIL reset_state observed=%h expected=0", {out_valid, edge_mag, edge_bit, out_sof});
    end
    rst = 1'b1;
    checkEn = 1'b1;

    // Border masking across lines and a full frame wrap.
    edgeWin(1, 1);
    for (int i = 0; i < 59; i++) edgeWin(1, 0);
    idle(4);

    // Directed windows at unmasked positions.
    thresh = 8'd64;
    ensureUnmasked();
    applyStimulus(1, 0, 100, 100, 100, 100, 100, 100, 100, 100, 100);
    idle(4);
    thresh = 8'd200;
    ensureUnmasked();
    edgeWin(1, 0);
    idle(4);
    thresh = 8'd64;
    ensureUnmasked();
    applyStimulus(1, 0, 0, 0, 10, 0, 0, 10, 0, 0, 10);
    idle(4);
    thresh = 8'd40;
    ensureUnmasked();
    applyStimulus(1, 0, 0, 0, 10, 0, 0, 10, 0, 0, 10);
    idle(4);
    thresh = 8'd0;
    ensureUnmasked();
    applyStimulus(1, 0, 100, 100, 100, 100, 100, 100, 100, 100, 100);
    idle(4);

    // Bubble pattern 1,0,0,1,1.
    thresh = 8'd200;
    ensureUnmasked();
    edgeWin(1, 0);
    idle(2);
    edgeWin(1, 0);
    edgeWin(1, 0);
    for (int i = 0; i < 6; i++) edgeWin(1, 0);
    idle(4);

    // Start of frame arriving mid-line.
    ensureUnmasked();
    edgeWin(1, 0);
    edgeWin(1, 1);
    for (int i = 0; i < 20; i++) edgeWin(1, 0);
    idle(4);

    // Asynchronous reset with three windows in flight.
    ensureUnmasked();
    edgeWin(1, 0);
    edgeWin(1, 0);
    edgeWin(1, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    assertCount++;
    assert (out_valid === 1'b0) else begin
      failCount++;
      $error("[TB] FAIL async_reset_valid observed=%b expected=0", out_valid);
    end
    assertCount++;
    assert (edge_mag === 8'd0) else begin
      failCount++;
      $error("[TB] FAIL async_reset_mag observed=%0d expected=0", edge_mag);
    end
    sb.delete();
    mcol = 0;
    mrow = 0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 22; i++) edgeWin(1, 0);
    idle(5);

    assertCount++;
    assert (sb.size() == 0) else begin
      failCount++;
      $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end
    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
